// File: rtl/registro_pipeline_elastico.sv
// Elastic multi-stage pipeline register with valid/ready handshake on both sides.
// Bubbles collapse toward the output; synchronous flush drops in-flight words.
module registro_pipeline_elastico #(
  parameter  int unsigned N  = 16,
  parameter  int unsigned D  = 3,
  localparam int unsigned CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [N-1:0]  dato_entrada,
  input  logic          valido_entrada,
  output logic          listo_salida,
  output logic [N-1:0]  salida,
  output logic          valido_salida,
  input  logic          listo_entrada,
  output logic [CW-1:0] ocupacion
);

  logic [N-1:0] dato [D];
  logic [D-1:0] val;
  logic [D-1:0] puede;
  logic [D-1:0] src_val;
  logic [N-1:0] src_dato [D];
  logic         entra;
  logic         sale;

  // A stage may advance unless it and every stage downstream of it are full
  // while the consumer stalls; written in closed form to avoid a comb chain loop.
  for (genvar i = 0; i < D; i++) begin : g_puede
    assign puede[i] = listo_entrada | ~(&val[D-1:i]);
  end

  assign listo_salida  = puede[0] & ~flush;
  assign entra         = valido_entrada & listo_salida;
  assign sale          = val[D-1] & listo_entrada;
  assign salida        = dato[D-1];
  assign valido_salida = val[D-1];

  // Source of each stage: the input handshake for stage 0, the previous stage otherwise.
  always_comb begin
    src_val     = '0;
    src_dato[0] = dato_entrada;
    src_val[0]  = entra;
    for (int i = 1; i < D; i++) begin
      src_val[i]  = val[i-1];
      src_dato[i] = dato[i-1];
    end
  end

  // Stage registers; a bubble moving in clears valid but keeps the old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val <= '0;
      for (int i = 0; i < D; i++) begin
        dato[i] <= '0;
      end
    end else if (flush) begin
      val <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (puede[i]) begin
          val[i] <= src_val[i];
          if (src_val[i]) begin
            dato[i] <= src_dato[i];
          end
        end
      end
    end
  end

  // Occupancy tracks the number of valid stages, saturating at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ocupacion <= '0;
    end else if (flush) begin
      ocupacion <= '0;
    end else if (entra && !sale && ocupacion != CW'(D)) begin
      ocupacion <= ocupacion + CW'(1);
    end else if (sale && !entra && ocupacion != CW'(0)) begin
      ocupacion <= ocupacion - CW'(1);
    end
  end

endmodule

// File: doc/registro_pipeline_elastico.md
Name: registro_pipeline_elastico

Overview:
- Parametrised, multi-stage successor to the single enable-load pipeline register in the servo control datapath.
- Carries N-bit samples (duty values, position errors) through D register stages.
- Uses a valid/ready handshake on both sides, so a stalled consumer (PWM update, UART framer) back-pressures the producer without losing data.
- Bubbles collapse toward the output; a synchronous flush discards in-flight data, e.g. on a mode change.

Parameters:
- N, 16, data width in bits (>=1).
- D, 3, number of pipeline stages (>=1).
- CW, $clog2(D+1), width of the occupancy output (derived, not overridden).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of all in-flight data.
- dato_entrada  input  N  upstream data.
- valido_entrada  input  1  upstream data valid.
- listo_salida  output  1  block can accept dato_entrada this cycle.
- salida  output  N  data of last stage.
- valido_salida  output  1  salida is valid.
- listo_entrada  input  1  downstream accepts salida this cycle.
- ocupacion  output  CW  number of valid stages, 0..D.

Behaviour:
- State per stage i (0..D-1): dato[i] (N bits), val[i] (1 bit). Stage D-1 drives salida/valido_salida directly (registered, no combinational path from data input).
- Reset (async, any time, including mid-transfer): all dato[i]=0, all val[i]=0. Outputs go low/zero immediately: salida=0, valido_salida=0, ocupacion=0. listo_salida follows the combinational rule below.
- Advance chain (combinational):
  - puede[D] = listo_entrada.
  - puede[i] = !val[i] | puede[i+1].
  - listo_salida = puede[0] & !flush.
- Per clock, for stage i with puede[i]=1 (and no flush):
  - val[i] <= source valid, where the source is stage i-1, or the input handshake for i=0 (valido_entrada & listo_salida).
  - dato[i] <= source data only when source valid=1; otherwise dato[i] holds (bubble moves in, data kept).
- Stage with puede[i]=0 holds both dato and val.
- Transfers: input transfer when valido_entrada & listo_salida; output transfer when valido_salida & listo_entrada. Both may occur in the same cycle; a full pipeline with listo_entrada=1 accepts a new word every cycle.
- Latency: D cycles from input transfer to valido_salida with an empty pipe and no stall. Throughput is 1 word/cycle.
- Bubble collapse: a stalled output with empty upstream stages still lets new words advance until every stage is valid.
- Full: all val=1 and listo_entrada=0 → listo_salida=0, all stages hold.
- Empty: all val=0 → valido_salida=0; salida keeps its last value, which is don't-care for the consumer.
- Flush, at a rising edge with flush=1:
  - all val <= 0 and dato holds; the input is not accepted (listo_salida=0 that cycle).
  - Any output transfer in that cycle is still considered taken by downstream; the block does not re-present the word.
- ocupacion is registered and equals the popcount of val after each edge:
  - +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
  - 0 on flush/reset.
  - Never exceeds D or wraps.
- Ordering is strictly FIFO; no word is duplicated or dropped except by flush or reset.
- The valid/ready rule is the same for D=1: a single stage with pass-through readiness.

Test Plan:
- N=16, D=3, listo_entrada=1; drive 0x0001,0x0002,0x0003 on consecutive cycles → salida 0x0001,0x0002,0x0003 on cycles 3,4,5 after the first accept; ocupacion peaks at 3, returns to 0.
- Fill with 0x00A1..0x00A3 while listo_entrada=0 → listo_salida drops after the 3rd accept, ocupacion=3; offer 0x00A4 → not accepted; raise listo_entrada for 4 cycles → outputs A1,A2,A3 in order; A4 accepted on the first release cycle.
- Single word 0x1234 with listo_entrada=0, then 2 cycles idle → word collapses to stage 2; next input 0x5678 packs behind it; release → 0x1234 then 0x5678 back-to-back.
- Pipe full (0xBEEF,0xCAFE,0xF00D), assert flush 1 cycle with valido_entrada=1 → next cycle valido_salida=0, ocupacion=0, input word not captured; subsequent 0x0042 emerges after 3 cycles.
- Assert reset asynchronously mid-stream, between clock edges → salida=0, valido_salida=0, ocupacion=0 immediately; after release, traffic resumes with correct latency.
- Random valido_entrada/listo_entrada (10k cycles, D=1 and D=5) against a scoreboard queue → order preserved, no loss/duplication, ocupacion matches the queue depth every cycle.
